// File: rtl/correction_pkg.sv
// correction_pkg: constants and types shared by the Correction block and its
// LUT-load stage.
//   LUT_DEPTH   words per LUT (640x512 frame)
//   LUT_WIDTH   width of one distortion-LUT word
//   LANE_WIDTH  width of each SRAM DQ lane
//   ADDR_WIDTH  SRAM write-address width (2^ADDR_WIDTH >= LUT_DEPTH)
//   LANE_*      bit-slice positions of the LUT word inside the DQ lanes
//   lut_state_e loader FSM states
package correction_pkg;

    localparam int LUT_DEPTH  = 327680;
    localparam int LUT_WIDTH  = 20;
    localparam int LANE_WIDTH = 9;
    localparam int ADDR_WIDTH = 19;

    // Word-to-lane mapping; Correction reads the lanes back with the same slices.
    localparam int LANE_A_LSB  = 0;
    localparam int LANE_A_BITS = 9;
    localparam int LANE_B_LSB  = 9;
    localparam int LANE_B_BITS = 9;
    localparam int LANE_C_LSB  = 18;
    localparam int LANE_C_BITS = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } lut_state_e;

endpackage

// File: rtl/lut_loader_if.sv
// lut_loader_if: LUT word stream into the loader.
//   lutIn       LUT word
//   lutInValid  lutIn holds a word
//   lutInReady  sink takes the word this cycle
// Handshake: a word moves on every rising clk edge where lutInValid and
// lutInReady are both high; a source holds lutIn/lutInValid stable until then.
// Modports: master = word source, slave = loader.
interface lut_loader_if;
    import correction_pkg::*;

    logic [LUT_WIDTH-1:0] lutIn;
    logic                 lutInValid;
    logic                 lutInReady;

    modport master (output lutIn, output lutInValid, input lutInReady);
    modport slave  (input lutIn, input lutInValid, output lutInReady);
endinterface

// File: rtl/lut_lane_packer.sv
// lut_lane_packer: registered splitter of one LUT word into four SRAM lanes.
//   clk, rst   clock, synchronous active-high reset (lanes clear to 0)
//   load_en_i  capture word_i on this edge; otherwise lanes hold
//   word_i     LUT word
//   dq*_o      lane outputs (A = low 9 bits, B = next 9, C = top 2, D = 0)
module lut_lane_packer
    import correction_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en_i,
    input  logic [LUT_WIDTH-1:0]  word_i,
    output logic [LANE_WIDTH-1:0] dqa_o,
    output logic [LANE_WIDTH-1:0] dqb_o,
    output logic [LANE_WIDTH-1:0] dqc_o,
    output logic [LANE_WIDTH-1:0] dqd_o
);

    logic [LANE_WIDTH-1:0] dqa_q, dqb_q, dqc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dqa_q <= '0;
            dqb_q <= '0;
            dqc_q <= '0;
        end else if (load_en_i) begin
            dqa_q <= LANE_WIDTH'(word_i[LANE_A_LSB +: LANE_A_BITS]);
            dqb_q <= LANE_WIDTH'(word_i[LANE_B_LSB +: LANE_B_BITS]);
            dqc_q <= LANE_WIDTH'(word_i[LANE_C_LSB +: LANE_C_BITS]);
        end
    end

    assign dqa_o = dqa_q;
    assign dqb_o = dqb_q;
    assign dqc_o = dqc_q;
    assign dqd_o = '0;   // lane D carries no LUT bits

endmodule

// File: rtl/lut_loader.sv
// lut_loader: writes one full distortion LUT into Correction's SRAM per start.
//   clk, rst        clock, synchronous active-high reset
//   start           begin a load (honoured in IDLE and DONE)
//   abort           back to IDLE next cycle, no further writes; beats start
//   lut_if          LUT word stream (slave side)
//   nW              active-low SRAM write strobe, one cycle after each accept
//   addr            write address, valid while nW=0
//   DQ[a-d]_write   write-data lanes
//   busy            high in LOAD
//   loadDone        high in DONE
//   checksum        sum of written words; live only with LUT_LOADER_CHECKSUM_EN
//   dbgState        current FSM state
// Parameter DEPTH sets words per LUT (defaults to the frame-sized LUT).
// Optional macro: LUT_LOADER_CHECKSUM_EN enables the checksum accumulator.
module lut_loader
    import correction_pkg::*;
#(
    parameter int DEPTH = LUT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    lut_loader_if.slave           lut_if,
    output logic                  nW,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [LANE_WIDTH-1:0] DQa_write,
    output logic [LANE_WIDTH-1:0] DQb_write,
    output logic [LANE_WIDTH-1:0] DQc_write,
    output logic [LANE_WIDTH-1:0] DQd_write,
    output logic                  busy,
    output logic                  loadDone,
    output logic [31:0]           checksum,
    output lut_state_e            dbgState
);

    lut_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  nw_q;
    logic                  accept;
    logic                  wr_en;
    logic                  load_start;
    logic                  last_word;

    assign lut_if.lutInReady = (state_q == ST_LOAD);
    assign accept            = lut_if.lutInValid & lut_if.lutInReady;
    // A word accepted in the abort cycle is swallowed, never written.
    assign wr_en             = accept & ~abort;
    assign last_word         = (count_q == ADDR_WIDTH'(DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        load_start = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d    = ST_LOAD;
                        count_d    = '0;
                        load_start = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        count_d = count_q + 1'b1;
                        // Leaving LOAD drops ready on this same edge.
                        if (last_word) state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            nw_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            nw_q    <= ~wr_en;
            if (wr_en)           addr_q <= count_q;
            else if (load_start) addr_q <= '0;
        end
    end

    lut_lane_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .load_en_i (wr_en),
        .word_i    (lut_if.lutIn),
        .dqa_o     (DQa_write),
        .dqb_o     (DQb_write),
        .dqc_o     (DQc_write),
        .dqd_o     (DQd_write)
    );

`ifdef LUT_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk) begin
        if (rst)             checksum_q <= '0;
        else if (load_start) checksum_q <= '0;
        else if (wr_en)      checksum_q <= checksum_q + 32'(lut_if.lutIn);
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign nW       = nw_q;
    assign addr     = addr_q;
    assign busy     = (state_q == ST_LOAD);
    assign loadDone = (state_q == ST_DONE);
    assign dbgState = state_q;

endmodule
